sa_wdata_order_arbiter: RTL
===========================

Name: sa_WDATA_order_arbiter

Overview:
- Slave-side W-channel arbiter. One instance per slave port of the interconnect.
- Takes the per-master W streams produced by the master-side W dispatchers: data, last, valid, plus the per-slave select bit.
- Forwards exactly one master's write burst at a time to the slave. Bursts are forwarded in the order in which the slave-side AW arbiter granted the corresponding AW transactions.
- Grant order is held in an internal order FIFO, popped on each accepted WLAST beat. This keeps W bursts from interleaving and keeps W order consistent with AW order.

Parameters:
- MST_AMT, 2, number of masters (dispatchers) feeding this slave.
- DATA_WIDTH, 32, W data width.
- MST_ID_W, $clog2(MST_AMT), width of a master index.
- ORD_DEPTH, 4, order FIFO entries; power of two, ≥ 2.

Ports:
- ACLK_i  in  1  clock; all state updates on its rising edge.
- ARESET_i  in  1  reset, synchronous, active-high.
- aw_grant_valid_i  in  1  an AW transfer to this slave completed this cycle.
- aw_grant_mst_id_i  in  MST_ID_W  master index of that AW transfer.
- aw_grant_ready_o  out  1  order FIFO can accept a grant; the AW arbiter must not grant while low.
- dsp_WDATA_i  in  DATA_WIDTH*MST_AMT  per-master W data; master m occupies slice [DATA_WIDTH*(m+1)-1 -: DATA_WIDTH].
- dsp_WLAST_i  in  MST_AMT  per-master WLAST.
- dsp_WVALID_i  in  MST_AMT  per-master WVALID.
- dsp_WDATA_sel_i  in  MST_AMT  per-master flag: master's current W data targets this slave.
- dsp_WREADY_o  out  MST_AMT  per-master WREADY back to the dispatchers.
- s_WDATA_o  out  DATA_WIDTH  W data to slave.
- s_WLAST_o  out  1  WLAST to slave.
- s_WVALID_o  out  1  WVALID to slave.
- s_WREADY_i  in  1  slave WREADY.
- ord_cnt_o  out  $clog2(ORD_DEPTH)+1  current order FIFO occupancy.

Behaviour:
- Reset (ARESET_i high at a clock edge):
  - FIFO pointers and count cleared; state = IDLE.
  - While ARESET_i is high, these outputs are 0: aw_grant_ready_o, s_WVALID_o, dsp_WREADY_o, s_WDATA_o, s_WLAST_o, ord_cnt_o.
  - Reset asserted mid-burst discards the in-flight burst and all queued grants; no partial pop.
- Order FIFO:
  - Push when aw_grant_valid_i && aw_grant_ready_o.
  - aw_grant_ready_o = ~full. A pop in the same cycle does not free space for a push when full (registered-only ready).
  - A push attempted while full is ignored; this is a protocol violation by the upstream AW arbiter.
  - Pointers wrap modulo ORD_DEPTH. Count is one bit wider than the pointers so that full = (cnt == ORD_DEPTH).
  - Simultaneous push and pop with FIFO not full: count unchanged, both pointers advance.
- State machine:
  - IDLE → BURST when the FIFO is non-empty.
  - BURST holds cur_id = FIFO head.
  - BURST → IDLE on an accepted beat (s_WVALID_o && s_WREADY_i && s_WLAST_o) when the FIFO holds no further entry after the pop.
  - BURST → BURST with the new head when another entry remains. Back-to-back bursts have zero bubble.
- Routing in BURST (combinational from inputs):
  - s_WVALID_o = dsp_WVALID_i[cur_id] & dsp_WDATA_sel_i[cur_id].
  - s_WDATA_o and s_WLAST_o = slice/bit cur_id.
  - dsp_WREADY_o[cur_id] = s_WREADY_i & dsp_WDATA_sel_i[cur_id]; all other bits 0.
- IDLE: s_WVALID_o = 0, s_WDATA_o = 0, s_WLAST_o = 0, dsp_WREADY_o = 0.
- A beat transfers only when s_WVALID_o && s_WREADY_i. Non-last beats do not pop.
- Valid from a master other than cur_id is held off (its WREADY stays 0) until its grant reaches the head.
- Latency: a grant pushed into an empty FIFO routes from the next cycle (one cycle AW→W).
- ord_cnt_o = registered FIFO count.

Optional Feature:
- Macro: SA_WDATA_ORD_BYPASS_EN.
- Defined:
  - When the FIFO is empty and in IDLE, a grant in cycle N is routed combinationally in cycle N itself; cur_id = aw_grant_mst_id_i.
  - If that cycle also carries an accepted WLAST beat, the grant is consumed without being pushed.
  - Otherwise the grant is pushed as normal.
- Undefined: one-cycle AW→W latency as above; no combinational path from aw_grant_* to the W outputs.

Test Plan:
- Reset then idle: hold ARESET_i 3 cycles, release → aw_grant_ready_o = 1, s_WVALID_o = 0, ord_cnt_o = 0.
- Single burst: grant id 1; master 1 sends 4 beats 0xA0..0xA3, last on 4th, sel[1] = 1, s_WREADY_i = 1 → s_WDATA_o = 0xA0..0xA3 on consecutive cycles starting the cycle after the grant; WLAST on 0xA3; ord_cnt_o 1 → 0.
- Ordering: grants id 1 then id 0; master 0 valid first with 0x10,0x11(last) → master 0 stalled (dsp_WREADY_o = 2'b00 at first, then 2'b10 only for master 1) until master 1's burst 0xB0(last) completes; then 0x10,0x11 pass with zero bubble.
- Full FIFO: with ORD_DEPTH = 4, push 4 grants with no W traffic → ord_cnt_o = 4, aw_grant_ready_o = 0; a 5th grant is ignored; one WLAST pop → ready returns to 1 the next cycle.
- Backpressure: s_WREADY_i toggles 1,0,0,1 during a 3-beat burst → every beat is delivered exactly once, WDATA stable while stalled, pop only on the last accepted beat.
- Mid-burst reset: assert ARESET_i after beat 2 of 4 with 2 grants queued → next cycle all outputs 0, ord_cnt_o = 0; after release, a new grant routes normally.

Source files
------------

// File: rtl/sa_wdata_order_arbiter.sv
// Slave-side W-channel arbiter: forwards whole W bursts one at a time, in AW grant order.
// Optional macro SA_WDATA_ORD_BYPASS_EN routes a grant into an empty, idle arbiter in the same cycle.
module sa_wdata_order_arbiter #(
  parameter int MST_AMT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MST_ID_W   = $clog2(MST_AMT),
  parameter int ORD_DEPTH  = 4
) (
  input  logic                          ACLK_i,
  input  logic                          ARESET_i,
  input  logic                          aw_grant_valid_i,
  input  logic [MST_ID_W-1:0]           aw_grant_mst_id_i,
  output logic                          aw_grant_ready_o,
  input  logic [DATA_WIDTH*MST_AMT-1:0] dsp_WDATA_i,
  input  logic [MST_AMT-1:0]            dsp_WLAST_i,
  input  logic [MST_AMT-1:0]            dsp_WVALID_i,
  input  logic [MST_AMT-1:0]            dsp_WDATA_sel_i,
  output logic [MST_AMT-1:0]            dsp_WREADY_o,
  output logic [DATA_WIDTH-1:0]         s_WDATA_o,
  output logic                          s_WLAST_o,
  output logic                          s_WVALID_o,
  input  logic                          s_WREADY_i,
  output logic [$clog2(ORD_DEPTH):0]    ord_cnt_o,
  output logic                          dbg_state_o
);

  localparam int PTR_W = $clog2(ORD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshakes: a grant is pushed when aw_grant_valid_i && aw_grant_ready_o at a rising
  // edge; a W beat moves when valid && ready at a rising edge; valid never waits on ready.
  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_nxt;
  logic [MST_ID_W-1:0] ord_mem [ORD_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    cnt;
  logic                full, empty;
  logic                push, pop, byp, route_act, beat_last;
  logic [MST_ID_W-1:0] head_id, route_id;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                sel_valid, sel_last, sel_sel;

  assign full             = (cnt == CNT_W'(ORD_DEPTH));
  assign empty            = (cnt == '0);
  assign head_id          = ord_mem[rd_ptr];
  assign aw_grant_ready_o = !ARESET_i && !full;
  assign ord_cnt_o        = ARESET_i ? '0 : cnt;
  assign dbg_state_o      = (state == BURST);

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Grant storage needs no reset: entries are only read below the count.
  always_ff @(posedge ACLK_i) begin
    if (push) ord_mem[wr_ptr] <= aw_grant_mst_id_i;
  end

  always_comb begin
    byp       = 1'b0;
    route_id  = head_id;
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_sel   = 1'b0;
    state_nxt = state;
`ifdef SA_WDATA_ORD_BYPASS_EN
    byp = (state == IDLE) && empty && aw_grant_valid_i && !ARESET_i;
    if (byp) route_id = aw_grant_mst_id_i;
`endif
    route_act = ((state == BURST) || byp) && !ARESET_i;

    for (int m = 0; m < MST_AMT; m++) begin
      if (route_id == MST_ID_W'(m)) begin
        sel_data  = dsp_WDATA_i[DATA_WIDTH*m +: DATA_WIDTH];
        sel_valid = dsp_WVALID_i[m];
        sel_last  = dsp_WLAST_i[m];
        sel_sel   = dsp_WDATA_sel_i[m];
      end
    end

    s_WVALID_o   = route_act && sel_valid && sel_sel;
    s_WDATA_o    = route_act ? sel_data : '0;
    s_WLAST_o    = route_act && sel_last;
    dsp_WREADY_o = '0;
    for (int m = 0; m < MST_AMT; m++) begin
      if (route_act && (route_id == MST_ID_W'(m)))
        dsp_WREADY_o[m] = s_WREADY_i && dsp_WDATA_sel_i[m];
    end

    beat_last = s_WVALID_o && s_WREADY_i && s_WLAST_o;
    pop       = (state == BURST) && beat_last;
    // A bypassed grant whose whole burst finishes in the same cycle is never stored.
    push      = aw_grant_valid_i && aw_grant_ready_o && !(byp && beat_last);

    case (state)
      IDLE:    if (!empty || push) state_nxt = BURST;
      BURST:   if (pop && (cnt == CNT_W'(1)) && !push) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
